// File: rtl/toggle_pkg.sv
// Shared constants and FSM encoding for the toggle event decoder.
// Synchronizer depth is 3 when TOGGLE_DEC_SYNC3_EN is defined, otherwise 2.
package toggle_pkg;

`ifdef TOGGLE_DEC_SYNC3_EN
    localparam int SYNC_DEPTH = 3;
`else
    localparam int SYNC_DEPTH = 2;
`endif

    localparam int CNT_W_DEFAULT = 4;
    localparam int WARM_W        = 3;

    typedef enum logic {
        WARMUP = 1'b0,
        ARMED  = 1'b1
    } dec_state_e;

    // Counter value that marks the last warm-up cycle.
    function automatic logic [WARM_W-1:0] warm_last();
        return WARM_W'(SYNC_DEPTH);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level; all stages reset to 0.
module sync_chain #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage_r;

    // Shift the asynchronous level through the flop chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_r <= '0;
        end else begin
            stage_r <= {stage_r[DEPTH-2:0], d};
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Converts a toggle-encoded asynchronous event line into a saturating pending-event count.
// Build option: TOGGLE_DEC_SYNC3_EN selects a 3-flop synchronizer (default 2).
module toggle_event_decoder
    import toggle_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tgl_in,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PEND_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              sync_s;
    logic              prev_r;
    logic              edge_s;
    dec_state_e        state_r;
    dec_state_e        state_nxt_s;
    logic [WARM_W-1:0] warm_cnt_r;
    logic [WARM_W-1:0] warm_cnt_nxt_s;
    logic              event_s;
    logic              pop_s;
    logic              full_s;
    logic [CNT_W-1:0]  pending_r;
    logic [CNT_W-1:0]  pending_nxt_s;
    logic              overflow_r;
    logic              ovf_set_s;
    logic              overflow_nxt_s;

    sync_chain #(
        .DEPTH (SYNC_DEPTH)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (tgl_in),
        .q       (sync_s)
    );

    // Delayed copy of the synchronized level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= sync_s;
        end
    end

    assign edge_s = sync_s ^ prev_r;

    // FSM state and warm-up counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= WARMUP;
            warm_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            warm_cnt_r <= warm_cnt_nxt_s;
        end
    end

    // Warm-up lasts SYNC_DEPTH+1 cycles so a reset-time level on tgl_in is absorbed.
    always_comb begin
        state_nxt_s    = state_r;
        warm_cnt_nxt_s = warm_cnt_r;
        case (state_r)
            WARMUP: begin
                if (warm_cnt_r == warm_last()) begin
                    state_nxt_s = ARMED;
                end else begin
                    warm_cnt_nxt_s = warm_cnt_r + {{(WARM_W-1){1'b0}}, 1'b1};
                end
            end
            ARMED: begin
                state_nxt_s = ARMED;
            end
            default: begin
                state_nxt_s    = WARMUP;
                warm_cnt_nxt_s = '0;
            end
        endcase
    end

    assign event_s = (state_r == ARMED) && edge_s;
    assign pop_s   = evt_valid && evt_ready;
    assign full_s  = (pending_r == PEND_MAX);

    // Pending counter update; an unpaired event at full is dropped and flagged.
    always_comb begin
        pending_nxt_s = pending_r;
        ovf_set_s     = 1'b0;
        case ({event_s, pop_s})
            2'b10: begin
                if (full_s) begin
                    ovf_set_s = 1'b1;
                end else begin
                    pending_nxt_s = pending_r + PEND_ONE;
                end
            end
            2'b01: begin
                pending_nxt_s = pending_r - PEND_ONE;
            end
            default: begin
                pending_nxt_s = pending_r;
            end
        endcase
    end

    // Sticky overflow: a new drop outranks a clear in the same cycle.
    always_comb begin
        overflow_nxt_s = overflow_r;
        if (ovf_set_s) begin
            overflow_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end
    end

    // Counter and overflow registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r  <= '0;
            overflow_r <= 1'b0;
        end else begin
            pending_r  <= pending_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    assign pending   = pending_r;
    assign overflow  = overflow_r;
    assign evt_valid = (pending_r != '0);

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed self-checking bench for toggle_event_decoder (CNT_W=4).
module tb_toggle_event_decoder;
    import toggle_pkg::*;

    localparam int D = SYNC_DEPTH;

    logic       clk;
    logic       reset_n;
    logic       tgl_in;
    logic       evt_ready;
    logic       clr_ovf;
    logic       evt_valid;
    logic [3:0] pending;
    logic       overflow;

    int checks;
    int errors;

    toggle_event_decoder #(.CNT_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tgl_in    (tgl_in),
        .evt_ready (evt_ready),
        .clr_ovf   (clr_ovf),
        .evt_valid (evt_valid),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        tgl_in    = 1'b1;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        tick(2);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        reset_n = 1'b1;
        tick(20);
        chk("warm_pending", 32'(pending), 32'd0);
        chk("warm_valid", 32'(evt_valid), 32'd0);
        chk("warm_ovf", 32'(overflow), 32'd0);

        // Latency: change sampled at next edge, visible D edges later.
        tgl_in = 1'b0;
        tick(D);
        chk("lat_early", 32'(pending), 32'd0);
        tick(1);
        chk("lat_pending", 32'(pending), 32'd1);
        chk("lat_valid", 32'(evt_valid), 32'd1);
        tick(3);

        tgl_in = 1'b1;
        tick(4);
        tgl_in = 1'b0;
        tick(4);
        chk("three_evt", 32'(pending), 32'd3);

        evt_ready = 1'b1;
        tick(1);
        chk("pop1", 32'(pending), 32'd2);
        tick(1);
        chk("pop2", 32'(pending), 32'd1);
        chk("pop2_valid", 32'(evt_valid), 32'd1);
        tick(1);
        chk("pop3", 32'(pending), 32'd0);
        chk("pop3_valid", 32'(evt_valid), 32'd0);
        tick(1);
        chk("no_underflow", 32'(pending), 32'd0);
        evt_ready = 1'b0;

        // Fill to saturation, then one more event overflows.
        for (int i = 0; i < 15; i++) begin
            tgl_in = ~tgl_in;
            tick(4);
        end
        chk("fill15_pending", 32'(pending), 32'd15);
        chk("fill15_ovf", 32'(overflow), 32'd0);
        tgl_in = ~tgl_in;
        tick(4);
        chk("ovf16_pending", 32'(pending), 32'd15);
        chk("ovf16_ovf", 32'(overflow), 32'd1);

        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Event and pop coincide at full.
        tgl_in = ~tgl_in;
        tick(D);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("full_pushpop_pending", 32'(pending), 32'd15);
        chk("full_pushpop_ovf", 32'(overflow), 32'd0);
        tick(3);

        // Clear coincident with an overflowing event: set wins.
        tgl_in = ~tgl_in;
        tick(D);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("set_wins_ovf", 32'(overflow), 32'd1);
        chk("set_wins_pending", 32'(pending), 32'd15);
        tick(3);

        evt_ready = 1'b1;
        tick(10);
        evt_ready = 1'b0;
        chk("drain_to5", 32'(pending), 32'd5);

        // Asynchronous reset mid-operation.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_pending", 32'(pending), 32'd0);
        chk("async_rst_valid", 32'(evt_valid), 32'd0);
        chk("async_rst_ovf", 32'(overflow), 32'd0);
        chk("async_rst_state", 32'(dut.state_r), 32'(WARMUP));
        tick(1);
        reset_n = 1'b1;
        tick(10);
        chk("post_rst_pending", 32'(pending), 32'd0);

        tgl_in = ~tgl_in;
        tick(D + 1);
        chk("post_rst_event", 32'(pending), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_event_decoder.md
TOGGLE_EVENT_DECODER -- requirements
Module: toggle_event_decoder

Interface
REQ-001 SHALL have parameter: CNT_W, default 4, width of the pending-event counter (range 2..8).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: tgl_in  input  1  toggle-encoded event line; asynchronous to clk; each level change is one event.
REQ-005 SHALL have port: evt_ready  input  1  consumer accepts one event.
REQ-006 SHALL have port: clr_ovf  input  1  synchronous clear of overflow.
REQ-007 SHALL have port: evt_valid  output  1  at least one event pending.
REQ-008 SHALL have port: pending  output  CNT_W  number of undelivered events.
REQ-009 SHALL have port: overflow  output  1  sticky; event dropped because counter full.

Function
REQ-010 SHALL pass tgl_in through a synchronizer chain of SYNC_DEPTH flops; the last stage is sync_q.
REQ-011 SHALL register sync_q into prev_q every cycle; edge = sync_q XOR prev_q.
REQ-012 SHALL contain a 2-state FSM: WARMUP, ARMED.
REQ-013 In WARMUP, edge SHALL be ignored; a warm-up counter SHALL advance each cycle; after SYNC_DEPTH+1 cycles the FSM SHALL enter ARMED and stay there until reset.
REQ-014 In ARMED, each cycle with edge=1 SHALL be one event.
REQ-015 Latency (ARMED, SYNC_DEPTH=2): tgl_in change sampled at edge k SHALL be visible in pending after edge k+2.
REQ-016 pending SHALL be updated as follows: +1 on event only; -1 on (evt_valid && evt_ready) only; unchanged on both or neither.
REQ-017 evt_valid SHALL equal (pending != 0), combinationally from the register.
REQ-018 With pending = 2^CNT_W-1, an event SHALL NOT be counted without a simultaneous pop.
REQ-019 In that case overflow SHALL be set at the same edge.
REQ-020 An event with a simultaneous pop at full SHALL leave pending unchanged and SHALL NOT set overflow.
REQ-021 evt_ready with pending = 0 SHALL have no effect; no underflow.
REQ-022 overflow SHALL be cleared by clr_ovf=1; set SHALL win over clr_ovf in the same cycle.
REQ-023 Events SHALL NOT be lost or duplicated when tgl_in changes at most once per SYNC_DEPTH+1 cycles.

Reset
REQ-024 reset_n low SHALL asynchronously clear the synchronizer flops, prev_q, warm-up counter, pending and overflow, and set the FSM to WARMUP.
REQ-025 During reset, evt_valid=0, pending=0, overflow=0.
REQ-026 Reset asserted mid-operation SHALL discard all pending events.
REQ-027 After release, a constant tgl_in=1 SHALL produce no event (WARMUP absorbs it).

Configuration
REQ-028 Macro TOGGLE_DEC_SYNC3_EN defined: SYNC_DEPTH=3; latency REQ-015 becomes k+3; warm-up becomes 4 cycles.
REQ-029 Macro TOGGLE_DEC_SYNC3_EN undefined: SYNC_DEPTH=2; all other behaviour identical.

Structure
REQ-030 Package toggle_pkg SHALL hold SYNC_DEPTH (macro-selected), the default CNT_W, and the FSM state encoding (WARMUP=0, ARMED=1).
REQ-031 Synchronizer SHALL be a separate sub-module sync_chain (parameter DEPTH, async active-low reset, resets to 0), instantiated once.

Verification
REQ-032 Reset release, tgl_in held 1, 20 cycles -> pending=0, evt_valid=0, overflow=0.
REQ-033 ARMED, evt_ready=0, toggle tgl_in 3 times spaced 4 cycles -> pending=3; then evt_ready=1 for 3 cycles -> pending 2,1,0, evt_valid drops after the third pop.
REQ-034 CNT_W=4, evt_ready=0, 16 spaced toggles -> pending=15 and overflow=1 at the 16th event; clr_ovf pulse -> overflow=0.
REQ-035 pending=15, event and pop in the same cycle -> pending=15, overflow=0; clr_ovf coincident with an overflowing event -> overflow=1.
REQ-036 Single toggle at edge k -> pending=1 after edge k+2 (k+3 with TOGGLE_DEC_SYNC3_EN); reset_n pulsed low with pending=5 -> pending=0 immediately, FSM in WARMUP.
